// File: rtl/mem_readback_streamer.sv
// rtl/mem_readback_streamer.sv - reads a block of words from memory port 2 and streams {addr, data} out
module mem_readback_streamer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [31:0]      mem_addr,
    output logic             mem_write_en,
    output logic             mem_rd_en,
    input  logic [31:0]      mem_data_out,
    input  logic             mem_excpt,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [31:0]      dout_data,
    output logic [31:0]      dout_addr,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t           r_state;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_next_addr;
    logic             r_rd_en;
    logic             r_inflight;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_issued;

    logic [31:0]      r_fifo_data [FIFO_DEPTH];
    logic [31:0]      r_fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_fcount;

    logic             w_pop;
    logic             w_capture;
    logic             w_exc;
    logic             w_push;
    logic [PTR_W+1:0] w_occ;
    logic             w_room;
    logic             w_issue;

    // The address register still holds the in-flight read's address in its capture cycle.
    assign w_pop     = (r_fcount != '0) && dout_ready;
    assign w_capture = (r_state == S_RUN) && r_inflight;
    assign w_exc     = w_capture && mem_excpt;
    assign w_push    = w_capture && !mem_excpt;
    assign w_occ     = {1'b0, r_fcount} + {{(PTR_W+1){1'b0}}, r_inflight};
    assign w_room    = w_occ < (PTR_W+2)'(FIFO_DEPTH);
    assign w_issue   = (r_state == S_RUN) && (r_issued < r_count) && w_room && !w_exc;

    assign mem_addr     = r_mem_addr;
    assign mem_write_en = 1'b0;
    assign mem_rd_en    = r_rd_en;
    assign dout_valid   = (r_fcount != '0);
    assign dout_data    = r_fifo_data[r_rd_ptr];
    assign dout_addr    = r_fifo_addr[r_rd_ptr];
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcount <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= mem_data_out;
                r_fifo_addr[r_wr_ptr] <= r_mem_addr;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fcount <= r_fcount + 1'b1;
                2'b01:   r_fcount <= r_fcount - 1'b1;
                default: r_fcount <= r_fcount;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_next_addr <= '0;
            r_rd_en     <= 1'b0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
            r_issued    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rd_en    <= 1'b0;
                    r_inflight <= 1'b0;
                    if (start) begin
                        r_err <= 1'b0;
                        if (word_count != '0) begin
                            // First read goes out on the start edge itself.
                            r_count     <= word_count;
                            r_issued    <= CNT_W'(1);
                            r_mem_addr  <= base_addr;
                            r_next_addr <= base_addr + 32'd4;
                            r_rd_en     <= 1'b1;
                            r_inflight  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    r_rd_en    <= w_issue;
                    r_inflight <= w_issue;
                    if (w_issue) begin
                        r_mem_addr  <= r_next_addr;
                        r_next_addr <= r_next_addr + 32'd4;
                        r_issued    <= r_issued + 1'b1;
                    end
                    if (w_exc) begin
                        r_err   <= 1'b1;
                        r_state <= S_DRAIN;
                    end else if ((r_issued == r_count) && !r_inflight) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_rd_en    <= 1'b0;
                    r_inflight <= 1'b0;
                    if (r_fcount == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end
                end
                default: begin
                    r_rd_en    <= 1'b0;
                    r_inflight <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_readback_streamer.sv
// tb/tb_mem_readback_streamer.sv - directed bench for mem_readback_streamer
module tb_mem_readback_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic        mem_rd_en;
    logic [31:0] mem_data_out;
    logic        mem_excpt;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [31:0] dout_data;
    logic [31:0] dout_addr;
    logic        busy;
    logic        done;
    logic        err;

    logic        exc_en = 1'b0;
    logic [31:0] exc_addr = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int run_id = 0;

    int seen_run = 0;
    int n_rd, n_pop, n_done, n_valid, max_occ, n_unstable, first_rd, first_val, done_cyc;
    logic        prev_stall;
    logic [31:0] prev_data, prev_addr;
    logic [31:0] q_data[$];
    logic [31:0] q_addr[$];
    int          q_cyc[$];

    mem_readback_streamer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_rd_en(mem_rd_en),
        .mem_data_out(mem_data_out), .mem_excpt(mem_excpt),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_addr(dout_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11111111;
            32'h4:   return 32'h22222222;
            32'h8:   return 32'h33333333;
            32'hC:   return 32'h44444444;
            default: return a ^ 32'hCAFE0000;
        endcase
    endfunction

    assign mem_data_out = mem_word(mem_addr);
    assign mem_excpt    = exc_en && (mem_addr == exc_addr);

    always @(negedge clk) begin
        if (run_id != seen_run) begin
            seen_run = run_id;
            n_rd = 0; n_pop = 0; n_done = 0; n_valid = 0; max_occ = 0; n_unstable = 0;
            first_rd = -1; first_val = -1; done_cyc = -1; prev_stall = 1'b0;
            q_data.delete(); q_addr.delete(); q_cyc.delete();
        end
        if (rst) begin
            if (mem_rd_en) begin
                n_rd = n_rd + 1;
                if (first_rd < 0) first_rd = cyc;
            end
            if (dout_valid) begin
                n_valid = n_valid + 1;
                if (first_val < 0) first_val = cyc;
            end
            if (done) begin
                n_done = n_done + 1;
                done_cyc = cyc;
            end
            if (n_rd - n_pop > max_occ) max_occ = n_rd - n_pop;
            if (prev_stall && (!dout_valid || dout_data !== prev_data || dout_addr !== prev_addr))
                n_unstable = n_unstable + 1;
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
            prev_addr  = dout_addr;
            if (dout_valid && dout_ready) begin
                q_data.push_back(dout_data);
                q_addr.push_back(dout_addr);
                q_cyc.push_back(cyc);
                n_pop = n_pop + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] c);
        @(posedge clk); #2;
        start = 1'b1; base_addr = b; word_count = c;
        run_id = run_id + 1;
        t0 = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && n_done == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input int n, input logic [31:0] a0, input logic [31:0] d0);
        check({tag, "_nwords"}, q_addr.size(), n);
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            check({tag, "_addr"}, q_addr[i], a0 + 32'(4 * i));
            check({tag, "_data"}, q_data[i], d0 + 32'(4 * i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ctrl", {mem_write_en, mem_rd_en, dout_valid, busy, done, err}, 32'h0);
        check("rst_dout_data", dout_data, 32'h0);
        check("rst_dout_addr", dout_addr, 32'h0);
        @(posedge clk); #2 rst = 1'b1;

        // basic dump
        dout_ready = 1'b1;
        do_start(32'h0, 16'd4);
        check("basic_busy", busy, 1'b1);
        wait_done(100);
        check("basic_ndone", n_done, 1);
        check("basic_done_lat", done_cyc - t0, 7);
        check("basic_first_rd", first_rd - t0, 1);
        check("basic_first_val", first_val - t0, 2);
        check("basic_nwords", q_addr.size(), 4);
        if (q_addr.size() == 4) begin
            check("basic_a0", q_addr[0], 32'h0);  check("basic_d0", q_data[0], 32'h11111111);
            check("basic_a1", q_addr[1], 32'h4);  check("basic_d1", q_data[1], 32'h22222222);
            check("basic_a2", q_addr[2], 32'h8);  check("basic_d2", q_data[2], 32'h33333333);
            check("basic_a3", q_addr[3], 32'hC);  check("basic_d3", q_data[3], 32'h44444444);
            check("basic_consec", q_cyc[3] - q_cyc[0], 3);
        end
        check("basic_err", err, 1'b0);
        check("basic_busy_end", busy, 1'b0);

        // backpressure, plus a start while busy that must be ignored
        do_start(32'h100, 16'd8);
        for (int i = 0; i < 6; i++) begin
            dout_ready = (i % 2 == 0);
            @(posedge clk); #2;
        end
        dout_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            base_addr = 32'h999; word_count = 16'd3;
            @(posedge clk); #2;
        end
        start = 1'b0;
        dout_ready = 1'b1;
        wait_done(200);
        check("bp_max_occ", max_occ, 4);
        check("bp_stable", n_unstable, 0);
        check("bp_ndone", n_done, 1);
        check("bp_nrd", n_rd, 8);
        check_stream("bp", 8, 32'h100, 32'hCAFE0100);
        check("bp_err", err, 1'b0);

        // address wrap
        do_start(32'hFFFFFFF8, 16'd4);
        wait_done(100);
        check("wrap_nwords", q_addr.size(), 4);
        if (q_addr.size() == 4) begin
            check("wrap_a0", q_addr[0], 32'hFFFFFFF8); check("wrap_d0", q_data[0], 32'h3501FFF8);
            check("wrap_a1", q_addr[1], 32'hFFFFFFFC); check("wrap_d1", q_data[1], 32'h3501FFFC);
            check("wrap_a2", q_addr[2], 32'h0);        check("wrap_d2", q_data[2], 32'h11111111);
            check("wrap_a3", q_addr[3], 32'h4);        check("wrap_d3", q_data[3], 32'h22222222);
        end

        // exception on the third word's capture
        exc_en = 1'b1; exc_addr = 32'h208;
        do_start(32'h200, 16'd6);
        wait_done(100);
        check("exc_ndone", n_done, 1);
        check("exc_nrd", n_rd, 3);
        check_stream("exc", 2, 32'h200, 32'hCAFE0200);
        check("exc_err", err, 1'b1);
        exc_en = 1'b0;
        repeat (5) @(negedge clk);
        check("exc_err_sticky", err, 1'b1);

        // zero count, also clears err
        do_start(32'h40, 16'd0);
        wait_done(50);
        check("zero_ndone", n_done, 1);
        check("zero_done_lat", done_cyc - t0, 1);
        check("zero_nrd", n_rd, 0);
        check("zero_nvalid", n_valid, 0);
        check("zero_err", err, 1'b0);

        // reset mid-run
        do_start(32'h300, 16'd8);
        for (int i = 0; i < 50 && !(dout_valid && dout_addr == 32'h308); i++) @(negedge clk);
        check("mid_reach_w3", dout_addr, 32'h308);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        check("mid_rst_ctrl", {mem_rd_en, dout_valid, busy, done, err}, 32'h0);
        check("mid_rst_dout_data", dout_data, 32'h0);
        check("mid_rst_dout_addr", dout_addr, 32'h0);
        repeat (3) @(negedge clk);
        check("mid_no_done", n_done, 0);
        @(posedge clk); #2 rst = 1'b1;
        do_start(32'h400, 16'd2);
        wait_done(50);
        check("post_ndone", n_done, 1);
        check_stream("post", 2, 32'h400, 32'hCAFE0400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
